// File: rtl/fbram_responder.sv
// Program/data RAM for the FBCPU core. It zero-fills, takes a program image over a valid/ready port, then serves the core.
// Optional CPU write protection of the low address range is enabled by defining FBRAM_PROTECT_EN.
module fbram_responder #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10,
    parameter int PROT_LIMIT    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] MAR,
    input  logic                     RAMWr,
    input  logic [DATA_WIDTH-1:0]    MDRIn,
    output logic [DATA_WIDTH-1:0]    MDROut,
    input  logic                     ld_valid,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    input  logic                     ld_last,
    output logic                     ld_ready,
    input  logic                     reload,
    output logic                     cpu_rst,
    output logic                     ld_done,
    output logic                     prot_viol,
    output logic [7:0]               prot_cnt
);
    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_RUN} state_t;

    state_t                   state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0] cptr_reg, lptr_reg;
    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [DATA_WIDTH-1:0]    mdrout_reg;

    logic                     load_accept;
    logic                     cpu_blocked;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;

    assign load_accept = ld_valid && (state_reg == ST_LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_CLEAR;
        end else begin
            state_reg <= state_next;
        end
    end

    // Clear pointer restarts from 0 whenever CLEAR is (re)entered; it wraps to 0 on its last word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cptr_reg <= '0;
            lptr_reg <= '0;
        end else begin
            if (state_reg == ST_CLEAR) begin
                cptr_reg <= cptr_reg + 1'b1;
            end else begin
                cptr_reg <= '0;
            end
            if (state_reg != ST_LOAD) begin
                lptr_reg <= '0;
            end else if (load_accept) begin
                lptr_reg <= lptr_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_CLEAR: if (cptr_reg == '1) state_next = ST_LOAD;
            ST_LOAD:  if (load_accept && (ld_last || lptr_reg == '1)) state_next = ST_RUN;
            ST_RUN:   if (reload) state_next = ST_CLEAR;
            default:  state_next = ST_CLEAR;
        endcase
    end

    always_comb begin
        ld_ready = (state_reg == ST_LOAD);
        ld_done  = (state_reg == ST_RUN);
        cpu_rst  = (state_reg != ST_RUN);
    end

    // Single write port shared by the clear sweep, the loader and the core.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cptr_reg;
        wr_data = '0;
        case (state_reg)
            ST_CLEAR: wr_en = 1'b1;
            ST_LOAD: begin
                wr_en   = load_accept;
                wr_addr = lptr_reg;
                wr_data = ld_data;
            end
            ST_RUN: begin
                wr_en   = RAMWr && !cpu_blocked;
                wr_addr = MAR;
                wr_data = MDRIn;
            end
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-first: the read register samples the array before a same-edge write lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdrout_reg <= '0;
        end else if (state_reg == ST_RUN) begin
            mdrout_reg <= mem[MAR];
        end else begin
            mdrout_reg <= '0;
        end
    end

    assign MDROut = mdrout_reg;

`ifdef FBRAM_PROTECT_EN
    localparam logic [ADDRESS_WIDTH:0] PROT_LIM = PROT_LIMIT[ADDRESS_WIDTH:0];

    logic       prot_hit;
    logic       prot_viol_reg;
    logic [7:0] prot_cnt_reg;

    assign cpu_blocked = ({1'b0, MAR} < PROT_LIM);
    assign prot_hit    = (state_reg == ST_RUN) && RAMWr && cpu_blocked;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prot_viol_reg <= 1'b0;
            prot_cnt_reg  <= '0;
        end else begin
            prot_viol_reg <= prot_hit;
            if (prot_hit && prot_cnt_reg != 8'hFF) begin
                prot_cnt_reg <= prot_cnt_reg + 1'b1;
            end
        end
    end

    assign prot_viol = prot_viol_reg;
    assign prot_cnt  = prot_cnt_reg;
`else
    logic prot_unused;

    assign prot_unused = (PROT_LIMIT != 0);
    assign cpu_blocked = 1'b0;
    assign prot_viol   = 1'b0;
    assign prot_cnt    = '0;
`endif

endmodule

// File: tb/tb_fbram_responder.sv
// Self-checking bench for fbram_responder: directed scenarios plus random traffic against a word-array model.
module tb_fbram_responder;
    localparam int AW    = 6;
    localparam int DW    = 10;
    localparam int DEPTH = 64;
    localparam int PLIM  = 16;
`ifdef FBRAM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] MAR = '0;
    logic          RAMWr = 1'b0;
    logic [DW-1:0] MDRIn = '0;
    logic [DW-1:0] MDROut;
    logic          ld_valid = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          reload = 1'b0;
    logic          cpu_rst;
    logic          ld_done;
    logic          prot_viol;
    logic [7:0]    prot_cnt;

    always #5 clk = ~clk;

    fbram_responder #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .PROT_LIMIT(PLIM)) dut (
        .clk(clk), .rst(rst), .MAR(MAR), .RAMWr(RAMWr), .MDRIn(MDRIn), .MDROut(MDROut),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .reload(reload), .cpu_rst(cpu_rst), .ld_done(ld_done),
        .prot_viol(prot_viol), .prot_cnt(prot_cnt)
    );

    int total = 0;
    int bad   = 0;
    int acc   = 0;

    // Model: a word array, a countdown of remaining zero-fill words, and a loading flag.
    logic [DW-1:0] m_mem [DEPTH];
    int            clear_left = DEPTH;
    bit            loading    = 1'b0;
    int            load_idx   = 0;
    logic [DW-1:0] e_mdr      = '0;
    bit            e_viol     = 1'b0;
    int            e_cnt      = 0;

    function automatic void model_reset();
        clear_left = DEPTH;
        loading    = 1'b0;
        load_idx   = 0;
        e_mdr      = '0;
        e_viol     = 1'b0;
        e_cnt      = 0;
    endfunction

    function automatic void model_step();
        if (!rst) begin
            model_reset();
            return;
        end
        e_viol = 1'b0;
        if (clear_left > 0) begin
            m_mem[DEPTH - clear_left] = '0;
            clear_left--;
            if (clear_left == 0) begin
                loading  = 1'b1;
                load_idx = 0;
            end
            e_mdr = '0;
        end else if (loading) begin
            e_mdr = '0;
            if (ld_valid) begin
                m_mem[load_idx] = ld_data;
                if (ld_last || load_idx == DEPTH - 1) loading = 1'b0;
                load_idx++;
            end
        end else begin
            e_mdr = m_mem[MAR];
            if (RAMWr) begin
                if (PROT && int'(MAR) < PLIM) begin
                    e_viol = 1'b1;
                    if (e_cnt < 255) e_cnt++;
                end else begin
                    m_mem[MAR] = MDRIn;
                end
            end
            if (reload) clear_left = DEPTH;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit running;
        running = (clear_left == 0) && !loading;
        check("mdrout",    32'(MDROut),    32'(e_mdr));
        check("ld_ready",  32'(ld_ready),  32'(loading));
        check("ld_done",   32'(ld_done),   32'(running));
        check("cpu_rst",   32'(cpu_rst),   32'(!running));
        check("prot_viol", 32'(prot_viol), 32'(e_viol));
        check("prot_cnt",  32'(prot_cnt),  32'(e_cnt));
    endtask

    // One clock: model advances on the edge with the inputs the DUT saw, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ld_ready && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic load_word(input logic [DW-1:0] d, input bit last);
        int gap;
        gap = int'($urandom_range(0, 3));
        ld_valid = 1'b0;
        for (int g = 0; g < gap; g++) step();
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        if (ld_ready) acc++;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    logic [DW-1:0] words [DEPTH];

    initial begin
        int n;
        step();
        step();
        check("reset_cpu_rst",  32'(cpu_rst),  32'd1);
        check("reset_ld_ready", 32'(ld_ready), 32'd0);
        check("reset_mdrout",   32'(MDROut),   32'd0);
        check("reset_prot_cnt", 32'(prot_cnt), 32'd0);

        rst = 1'b1;
        wait_ready(n);
        check("clear_cycles", 32'(n), 32'd64);

        acc = 0;
        load_word(10'h240, 1'b0);
        load_word(10'h081, 1'b0);
        load_word(10'h180, 1'b1);
        check("load3_accepts", 32'(acc), 32'd3);
        check("load3_done",    32'(ld_done), 32'd1);

        MAR = 6'd1;  step(); check("read_addr1",  32'(MDROut), 32'h081);
        MAR = 6'd2;  step(); check("read_addr2",  32'(MDROut), 32'h180);
        MAR = 6'd10; step(); check("read_unload", 32'(MDROut), 32'h000);

        MAR = 6'd40; RAMWr = 1'b1; MDRIn = 10'h155;
        step(); check("write_read_old", 32'(MDROut), 32'h000);
        RAMWr = 1'b0;
        step(); check("write_read_new", 32'(MDROut), 32'h155);

        MAR = 6'd5; RAMWr = 1'b1; MDRIn = 10'h2AA;
        step(); check("prot_pulse", 32'(prot_viol), PROT ? 32'd1 : 32'd0);
        RAMWr = 1'b0;
        step();
        check("prot_mem5",  32'(MDROut),   PROT ? 32'h000 : 32'h2AA);
        check("prot_cnt1",  32'(prot_cnt), PROT ? 32'd1 : 32'd0);
        RAMWr = 1'b1;
        for (int i = 0; i < 299; i++) step();
        RAMWr = 1'b0;
        step();
        check("prot_cnt_sat", 32'(prot_cnt), PROT ? 32'd255 : 32'd0);

        for (int i = 0; i < 300; i++) begin
            MAR   = AW'($urandom);
            RAMWr = ($urandom_range(0, 2) == 0);
            MDRIn = DW'($urandom);
            step();
        end

        MAR = 6'd50; RAMWr = 1'b1; MDRIn = 10'h3C3; reload = 1'b1;
        step();
        reload = 1'b0; RAMWr = 1'b0;
        check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        wait_ready(n);
        check("reload_clear_cycles", 32'(n), 32'd64);
        acc = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            words[i % DEPTH] = (i < DEPTH) ? DW'($urandom) : words[i % DEPTH];
            load_word((i < DEPTH) ? words[i % DEPTH] : 10'h3FF, 1'b0);
        end
        check("load64_accepts", 32'(acc), 32'd64);
        check("load64_ready",   32'(ld_ready), 32'd0);
        MAR = 6'd63; step(); check("load64_word63", 32'(MDROut), 32'(words[63]));
        MAR = 6'd0;  step(); check("load64_word0",  32'(MDROut), 32'(words[0]));

        reload = 1'b1; step(); reload = 1'b0;
        wait_ready(n);
        load_word(10'h111, 1'b0);
        load_word(10'h222, 1'b0);
        ld_valid = 1'b1; ld_data = 10'h333;
        rst = 1'b0;
        step();
        check("midload_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        step();
        rst = 1'b1; ld_valid = 1'b0;
        wait_ready(n);
        check("midload_clear_cycles", 32'(n), 32'd64);
        load_word(10'h0AB, 1'b1);
        MAR = 6'd1; step(); check("midload_word1_cleared", 32'(MDROut), 32'h000);
        MAR = 6'd0; step(); check("midload_word0_new",     32'(MDROut), 32'h0AB);

        for (int i = 0; i < 3000; i++) begin
            MAR      = AW'($urandom);
            RAMWr    = ($urandom_range(0, 2) == 0);
            MDRIn    = DW'($urandom);
            ld_valid = ($urandom_range(0, 1) == 0);
            ld_data  = DW'($urandom);
            ld_last  = ($urandom_range(0, 7) == 0);
            reload   = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
